// File: rtl/onehot_monitor.sv
// Receive-side checker for a rotating one-hot ring counter: decodes the sample,
// tracks sequence lock (HUNT/SYNC/LOCKED) and counts sequence errors while locked.
module onehot_monitor #(
  parameter int WIDTH  = 8,
  parameter int IDXW   = 3,
  parameter int LOCK_N = 4,
  parameter int ERRW   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] onehot_in,
  input  logic             in_valid,
  input  logic             clr_err,
  output logic [IDXW-1:0]  index,
  output logic             index_valid,
  output logic             illegal,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] prev_q, prev_d;
  logic [3:0]      good_q, good_d;
  logic [3:0]      good_inc;
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] exp_idx;
  logic            legal;
  logic            correct;
  logic            seq_err;

  // Handshake: there is no ready; onehot_in is consumed on every rising CLK edge
  // where in_valid is 1, and every cycle with in_valid=0 leaves all state untouched.

  // A power-of-two vector has exactly one bit set.
  assign legal = (onehot_in != '0) && ((onehot_in & (onehot_in - WIDTH'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_in[i]) idx = IDXW'(i);
    end
  end

  // WIDTH is a power of two, so the natural wrap of IDXW bits gives 7 -> 0.
  assign exp_idx  = prev_q + IDXW'(1);
  assign correct  = legal && (idx == exp_idx);
  assign good_inc = good_q + 4'd1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= HUNT;
      prev_q  <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    seq_err = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (legal) begin
            state_d = SYNC;
            prev_d  = idx;
            good_d  = '0;
          end
        end
        SYNC: begin
          if (correct) begin
            prev_d = idx;
            good_d = good_inc;
            if (good_inc == 4'(LOCK_N)) state_d = LOCKED;
          end else if (legal) begin
            prev_d = idx;
            good_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (correct) begin
            prev_d = idx;
          end else if (legal) begin
            seq_err = 1'b1;
            state_d = SYNC;
            prev_d  = idx;
            good_d  = '0;
          end else begin
            seq_err = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Clear is applied before counting, so a simultaneous error leaves the count at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
    end else begin
      index_valid <= in_valid && legal;
      illegal     <= in_valid && !legal;
      err_pulse   <= seq_err;
      if (in_valid && legal) index <= idx;
      if (clr_err) begin
        err_count <= seq_err ? ERRW'(1) : '0;
      end else if (seq_err && (err_count != '1)) begin
        err_count <= err_count + ERRW'(1);
      end
    end
  end

  assign locked    = (state_q == LOCKED);
  assign dbg_state = state_q;

endmodule

// File: doc/onehot_monitor.md
# onehot_monitor

Receive-side checker for the 8-bit one-hot ring counter. It samples the rotating one-hot vector and decodes it to a binary index. It verifies that every sample is legal (exactly one bit set) and that consecutive samples advance by one position (bit0→bit1→…→bit7→bit0). It reports lock status and a saturating error count, and sits downstream of the counter as its consumer and health monitor.

## Interface
- WIDTH, 8, width of the one-hot vector; must be a power of two ≥ 2.
- IDXW, 3, index width; equals log2(WIDTH).
- LOCK_N, 4, number of consecutive correct transitions required to enter LOCKED; range 1..15.
- ERRW, 8, width of the error counter.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-low.
- onehot_in  in  WIDTH  vector under test.
- in_valid  in  1  onehot_in is sampled on every CLK edge where this is 1.
- clr_err  in  1  synchronous clear of err_count.
- index  out  IDXW  bit position of the last legal sample.
- index_valid  out  1  one-cycle pulse: index was updated from a legal sample.
- illegal  out  1  one-cycle pulse: the last sample had zero bits set or two or more bits set.
- locked  out  1  level: the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse: a sequence error was detected while LOCKED.
- err_count  out  ERRW  number of err_pulse events, saturating at all-ones.

## Operation
- Decode
  - legal = popcount(onehot_in) == 1.
  - idx = position of the set bit.
  - exp = (prev + 1) mod WIDTH, where prev is the last stored legal index.
  - correct = legal && idx == exp.
- FSM states: HUNT, SYNC, LOCKED. Internal state is prev[IDXW-1:0] and good_cnt[3:0].
- HUNT
  - legal → SYNC, prev=idx, good_cnt=0.
  - illegal → stay in HUNT.
- SYNC
  - correct → prev=idx, good_cnt+1. When good_cnt+1 == LOCK_N, go to LOCKED.
  - legal but not correct → stay in SYNC, prev=idx, good_cnt=0.
  - illegal → HUNT.
- LOCKED
  - correct → stay, prev=idx.
  - legal but not correct → err_pulse, go to SYNC, prev=idx, good_cnt=0.
  - illegal → err_pulse, go to HUNT.
- in_valid=0: FSM, prev, good_cnt, index and err_count hold. All pulse outputs are 0.
- Output updates
  - index is written only on a legal sample.
  - index_valid = registered legal && in_valid.
  - illegal = registered !legal && in_valid.
  - An all-zero vector counts as illegal, which covers the counter being held in reset.
- err_count
  - Increments by 1 on each err_pulse and saturates at 2^ERRW-1.
  - clr_err forces it to 0.
  - clr_err and an error on the same edge: the result is 1, because clear is applied first and then the error is counted.
- Errors in HUNT or SYNC do not increment err_count. Only the illegal pulse reports them.

## Timing
- Reset (RST=0, asynchronous): state=HUNT, prev=0, good_cnt=0. Outputs: index=0, index_valid=0, illegal=0, locked=0, err_pulse=0, err_count=0.
- Reset release is synchronous to CLK. The first sample is taken on the first rising edge with RST=1 and in_valid=1.
- Latency: every output is registered and reflects the sample taken on the same edge. Outputs are visible one cycle after the edge where in_valid=1.
- Lock time: with a continuously correct sequence, locked rises on the edge of sample number LOCK_N+1, counted from the first legal sample in HUNT. With default parameters that is the 5th sample.
- Wrap-around: the transition from 0x80 to 0x01 (index 7→0) is correct and is not an error.
- Reset mid-operation: all state clears immediately, regardless of CLK. Any pulse in flight is dropped.
- No combinational path from any input to any output.

## Test plan
- Reset, then 12 consecutive valid samples 0x01,0x02,…,0x80,0x01,… → index_valid=1 on each. index follows 0,1,…,7,0. locked=1 from after sample 5 onward. err_count=0.
- While locked, inject 0x08 in place of the expected 0x04 → err_pulse=1 for one cycle, err_count=1, locked=0. Continuing from 0x10 relocks after 4 more correct samples.
- While locked, inject 0x00, then 0x03 → both illegal=1. The first asserts err_pulse and goes to HUNT. The second does not pulse err_pulse. err_count=1 and index holds its last legal value.
- Alternate in_valid 1/0 over the full correct sequence → behaviour identical to the continuous case. No pulses occur on cycles with in_valid=0.
- Force 300 errors while locked, relocking between them → err_count saturates at 0xFF. Asserting clr_err together with an error gives err_count=1, and clr_err alone gives 0.
- Assert RST low asynchronously between clock edges while locked → all outputs 0 immediately. After release, locked returns only after a new lock sequence.
